// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared field widths for the SPI transaction path
package spi_pkg;
  localparam int DWIDTH = 8;
  localparam int AWIDTH = 4;
endpackage

// File: rtl/spi_txn_queue_if.sv
// rtl/spi_txn_queue_if.sv - command, driver and response signals of spi_txn_queue
interface spi_txn_queue_if #(
  parameter int DWIDTH = spi_pkg::DWIDTH,
  parameter int AWIDTH = spi_pkg::AWIDTH
);
  localparam int WWIDTH = DWIDTH + AWIDTH + 5;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [WWIDTH-1:0] cmd_word;
  logic [1:0]        cmd_cfg;
  logic              master_en;
  logic [WWIDTH-1:0] driver_data;
  logic [1:0]        driver_cfg;
  logic              driver_read;
  logic [AWIDTH-1:0] spi_slv_addr;
  logic [DWIDTH-1:0] spi_slv_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [AWIDTH-1:0] rsp_addr;
  logic [DWIDTH-1:0] rsp_data;

  modport slave (
    input  cmd_valid, cmd_word, cmd_cfg, driver_read, spi_slv_addr, spi_slv_data, rsp_ready,
    output cmd_ready, master_en, driver_data, driver_cfg, rsp_valid, rsp_addr, rsp_data
  );

  modport master (
    output cmd_valid, cmd_word, cmd_cfg, driver_read, spi_slv_addr, spi_slv_data, rsp_ready,
    input  cmd_ready, master_en, driver_data, driver_cfg, rsp_valid, rsp_addr, rsp_data
  );
endinterface

// File: rtl/spi_txn_queue.sv
// rtl/spi_txn_queue.sv - command FIFO and issue FSM in front of spi_master
// Optional WAIT watchdog with sticky timeout_err: define SPI_TXN_TIMEOUT_EN.
module spi_txn_queue #(
  parameter int DWIDTH  = spi_pkg::DWIDTH,
  parameter int AWIDTH  = spi_pkg::AWIDTH,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  spi_txn_queue_if.slave  bus,
`ifdef SPI_TXN_TIMEOUT_EN
  output logic            timeout_err,
`endif
  output logic            busy
);
  localparam int WW = DWIDTH + AWIDTH + 5;
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [WW+1:0]   mem [DEPTH];
  logic [PW:0]     wr_ptr;
  logic [PW:0]     rd_ptr;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;

  assign empty         = (wr_ptr == rd_ptr);
  assign full          = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign bus.cmd_ready = !full;
  assign push          = bus.cmd_valid && !full;
  assign pop           = (state == IDLE) && !empty;
  assign busy          = !empty || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PW-1:0]] <= {bus.cmd_cfg, bus.cmd_word};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef SPI_TXN_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] wait_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      bus.master_en   <= 1'b0;
      bus.driver_data <= '0;
      bus.driver_cfg  <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_addr    <= '0;
      bus.rsp_data    <= '0;
`ifdef SPI_TXN_TIMEOUT_EN
      wait_cnt        <= '0;
      timeout_err     <= 1'b0;
`endif
    end else begin
      bus.master_en <= 1'b0;
      case (state)
        IDLE: begin
          // The pop and the driver register load share this edge so the word is stable for the whole ISSUE cycle.
          if (!empty) begin
            {bus.driver_cfg, bus.driver_data} <= mem[rd_ptr[PW-1:0]];
            bus.master_en <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef SPI_TXN_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (bus.driver_read) begin
            if (bus.driver_data[WW-1]) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_addr  <= bus.spi_slv_addr;
              bus.rsp_data  <= bus.spi_slv_data;
              state         <= RESP;
            end else begin
              state <= IDLE;
            end
          end
`ifdef SPI_TXN_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_txn_queue.sv
// tb/tb_spi_txn_queue.sv - self-checking bench for spi_txn_queue
module tb_spi_txn_queue;
  localparam int DW    = spi_pkg::DWIDTH;
  localparam int AW    = spi_pkg::AWIDTH;
  localparam int WW    = DW + AW + 5;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
`ifdef SPI_TXN_TIMEOUT_EN
  logic timeout_err;
`endif

  spi_txn_queue_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  spi_txn_queue #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
`ifdef SPI_TXN_TIMEOUT_EN
    .timeout_err (timeout_err),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: commands accepted but not yet completed, in order; occ counts those not yet issued.
  logic [WW+1:0] exp_q[$];
  int            occ = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [WW+1:0] rand_entry(input bit rd);
    logic [WW+1:0] e;
    e = (WW+2)'($urandom);
    e[WW-1] = rd;
    return e;
  endfunction

  task automatic push(input logic [WW+1:0] e);
    bus.cmd_word  = e[WW-1:0];
    bus.cmd_cfg   = e[WW+1:WW];
    bus.cmd_valid = 1'b1;
    chk("cmd_ready", bus.cmd_ready, (occ < DEPTH) ? 1 : 0);
    if (occ < DEPTH) begin
      exp_q.push_back(e);
      occ++;
    end
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic issue_check(input bit exact);
    logic [WW+1:0] e;
    int n;
    e = exp_q[0];
    if (exact) begin
      tick();
      chk("b2b_issue", bus.master_en, 1);
    end else begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!bus.master_en && n < 40);
      chk("issue_seen", bus.master_en, 1);
    end
    occ--;
    chk("driver_data", bus.driver_data, e[WW-1:0]);
    chk("driver_cfg", bus.driver_cfg, e[WW+1:WW]);
    tick();
    chk("pulse_width", bus.master_en, 0);
  endtask

  task automatic finish_one(input int stall, input int hold,
                            input logic [AW-1:0] addr, input logic [DW-1:0] data);
    logic [WW+1:0] e;
    e = exp_q.pop_front();
    for (int i = 0; i < stall; i++) begin
      chk("stable_data", bus.driver_data, e[WW-1:0]);
      chk("no_reissue", bus.master_en, 0);
      chk("busy_wait", busy, 1);
      tick();
    end
    bus.driver_read  = 1'b1;
    bus.spi_slv_addr = addr;
    bus.spi_slv_data = data;
    tick();
    bus.driver_read  = 1'b0;
    bus.spi_slv_addr = '0;
    bus.spi_slv_data = '0;
    if (e[WW-1]) begin
      chk("rsp_valid", bus.rsp_valid, 1);
      chk("rsp_addr", bus.rsp_addr, addr);
      chk("rsp_data", bus.rsp_data, data);
      for (int i = 0; i < hold; i++) begin
        tick();
        chk("rsp_hold", bus.rsp_valid, 1);
        chk("rsp_data_hold", bus.rsp_data, data);
        chk("resp_no_issue", bus.master_en, 0);
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk("rsp_drop", bus.rsp_valid, 0);
    end else begin
      chk("write_no_rsp", bus.rsp_valid, 0);
    end
    chk("busy_after", busy, (occ != 0) ? 1 : 0);
  endtask

  task automatic drain(input int stall_max, input int hold_max);
    bit was_write;
    while (exp_q.size() != 0) begin
      was_write = !exp_q[0][WW-1];
      finish_one($urandom_range(stall_max, 0), $urandom_range(hold_max, 0),
                 AW'($urandom), DW'($urandom));
      if (exp_q.size() != 0) issue_check(was_write);
    end
  endtask

  initial begin
    bus.cmd_valid    = 1'b0;
    bus.cmd_word     = '0;
    bus.cmd_cfg      = '0;
    bus.driver_read  = 1'b0;
    bus.spi_slv_addr = '0;
    bus.spi_slv_data = '0;
    bus.rsp_ready    = 1'b0;
    tick();
    tick();
    chk("rst_master_en", bus.master_en, 0);
    chk("rst_driver_data", bus.driver_data, 0);
    chk("rst_driver_cfg", bus.driver_cfg, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_addr", bus.rsp_addr, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    rst = 1'b0;
    tick();

    // single write of 0x1A5
    push({2'b01, WW'(17'h001A5)});
    issue_check(1'b0);
    finish_one(2, 0, '0, '0);

    // read with addr 3 / data 0x5C, response withheld 10 cycles while a write waits
    push(rand_entry(1'b1));
    issue_check(1'b0);
    push(rand_entry(1'b0));
    finish_one(1, 10, AW'(4'h3), DW'(8'h5C));
    issue_check(1'b0);
    drain(2, 2);

    // five commands against a stalled master: one in flight plus a full FIFO
    push(rand_entry(1'b0));
    issue_check(1'b0);
    for (int i = 0; i < 4; i++) push(rand_entry($urandom_range(1, 0)));
    for (int i = 0; i < 3; i++) push(rand_entry(1'b0));
    drain(3, 3);

    // randomized batches
    for (int b = 0; b < 8; b++) begin
      int n;
      n = $urandom_range(5, 1);
      push(rand_entry($urandom_range(1, 0)));
      issue_check(1'b0);
      for (int i = 1; i < n; i++) push(rand_entry($urandom_range(1, 0)));
      drain(3, 4);
    end

    // reset in WAIT with two commands queued
    push(rand_entry(1'b1));
    issue_check(1'b0);
    push(rand_entry(1'b0));
    push(rand_entry(1'b0));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_master_en", bus.master_en, 0);
    chk("mid_rst_driver_data", bus.driver_data, 0);
    chk("mid_rst_driver_cfg", bus.driver_cfg, 0);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
    exp_q.delete();
    occ = 0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("post_rst_idle", bus.master_en, 0);
      chk("post_rst_busy", busy, 0);
    end

`ifdef SPI_TXN_TIMEOUT_EN
    push(rand_entry(1'b0));
    push(rand_entry(1'b1));
    issue_check(1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk("timeout_pending", timeout_err, 0);
    tick();
    chk("timeout_err", timeout_err, 1);
    void'(exp_q.pop_front());
    issue_check(1'b1);
    drain(1, 1);
    chk("timeout_sticky", timeout_err, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
